// File: rtl/icb_sram_ctrl_if.sv
// ICB command/response bus between the command buffer (master) and the SRAM controller (slave).
interface icb_sram_ctrl_if #(
  parameter int AW    = 32,
  parameter int DW    = 32,
  parameter int USR_W = 1
);
  logic             i_icb_cmd_valid;
  logic             i_icb_cmd_ready;
  logic             i_icb_cmd_read;
  logic [AW-1:0]    i_icb_cmd_addr;
  logic [DW-1:0]    i_icb_cmd_wdata;
  logic [DW/8-1:0]  i_icb_cmd_wmask;
  logic             i_icb_cmd_excl;
  logic [USR_W-1:0] i_icb_cmd_usr;

  logic             i_icb_rsp_valid;
  logic             i_icb_rsp_ready;
  logic             i_icb_rsp_err;
  logic             i_icb_rsp_excl_ok;
  logic [DW-1:0]    i_icb_rsp_rdata;
  logic [USR_W-1:0] i_icb_rsp_usr;

  modport master (
    output i_icb_cmd_valid, i_icb_cmd_read, i_icb_cmd_addr, i_icb_cmd_wdata,
           i_icb_cmd_wmask, i_icb_cmd_excl, i_icb_cmd_usr, i_icb_rsp_ready,
    input  i_icb_cmd_ready, i_icb_rsp_valid, i_icb_rsp_err, i_icb_rsp_excl_ok,
           i_icb_rsp_rdata, i_icb_rsp_usr
  );

  modport slave (
    input  i_icb_cmd_valid, i_icb_cmd_read, i_icb_cmd_addr, i_icb_cmd_wdata,
           i_icb_cmd_wmask, i_icb_cmd_excl, i_icb_cmd_usr, i_icb_rsp_ready,
    output i_icb_cmd_ready, i_icb_rsp_valid, i_icb_rsp_err, i_icb_rsp_excl_ok,
           i_icb_rsp_rdata, i_icb_rsp_usr
  );
endinterface

// File: rtl/icb_sram_ctrl.sv
// Single-outstanding ICB-to-SRAM bridge; define ICB_SRAM_RANGE_CHK_EN to error addresses beyond SRAM depth.
// IDLE: no response | RSP_LIVE: response, rdata from sram_dout | RSP_HELD: response stalled, rdata from hold reg
module icb_sram_ctrl #(
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int SRAM_AW = 10,
  parameter int USR_W   = 1
) (
  input  logic               clk,
  input  logic               rst,
  icb_sram_ctrl_if.slave     icb,
  output logic               sram_cs,
  output logic               sram_we,
  output logic [DW/8-1:0]    sram_wem,
  output logic [SRAM_AW-1:0] sram_addr,
  output logic [DW-1:0]      sram_din,
  input  logic [DW-1:0]      sram_dout,
  output logic               sram_ctrl_active
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    RSP_LIVE = 2'd1,
    RSP_HELD = 2'd2
  } state_t;

  state_t           r_state;
  logic             r_read;
  logic             r_err;
  logic [USR_W-1:0] r_usr;
  logic [DW-1:0]    r_hold;

  logic             w_rsp_valid;
  logic             w_cmd_ready;
  logic             w_accept;
  logic             w_oor;
  logic             w_unused_bits;
  logic [DW-1:0]    w_live_rdata;

`ifdef ICB_SRAM_RANGE_CHK_EN
  assign w_oor         = |icb.i_icb_cmd_addr[AW-1:SRAM_AW+2];
  assign w_unused_bits = ^{icb.i_icb_cmd_addr[1:0], icb.i_icb_cmd_excl};
`else
  assign w_oor         = 1'b0;
  assign w_unused_bits = ^{icb.i_icb_cmd_addr[AW-1:SRAM_AW+2], icb.i_icb_cmd_addr[1:0],
                           icb.i_icb_cmd_excl};
`endif

  assign w_rsp_valid = (r_state != IDLE);
  assign w_cmd_ready = (r_state == IDLE) | (w_rsp_valid & icb.i_icb_rsp_ready);
  assign w_accept    = icb.i_icb_cmd_valid & w_cmd_ready;

  // Out-of-range commands are still accepted but never reach the SRAM.
  assign sram_cs   = w_accept & ~w_oor & ~rst;
  assign sram_we   = sram_cs & ~icb.i_icb_cmd_read;
  assign sram_wem  = sram_we ? icb.i_icb_cmd_wmask : '0;
  assign sram_addr = icb.i_icb_cmd_addr[SRAM_AW+1:2];
  assign sram_din  = icb.i_icb_cmd_wdata;

  assign w_live_rdata = (r_read & ~r_err) ? sram_dout : '0;

  assign icb.i_icb_cmd_ready   = w_cmd_ready;
  assign icb.i_icb_rsp_valid   = w_rsp_valid;
  assign icb.i_icb_rsp_err     = w_rsp_valid & r_err;
  assign icb.i_icb_rsp_excl_ok = 1'b0;
  assign icb.i_icb_rsp_usr     = r_usr;

  always_comb begin
    icb.i_icb_rsp_rdata = '0;
    case (r_state)
      RSP_LIVE: icb.i_icb_rsp_rdata = w_live_rdata;
      RSP_HELD: icb.i_icb_rsp_rdata = r_hold;
      default:  icb.i_icb_rsp_rdata = '0;
    endcase
  end

  assign sram_ctrl_active = icb.i_icb_cmd_valid | w_rsp_valid;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_read  <= 1'b0;
      r_err   <= 1'b0;
      r_usr   <= '0;
      r_hold  <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_accept) r_state <= RSP_LIVE;
        end
        RSP_LIVE: begin
          if (icb.i_icb_rsp_ready) begin
            r_state <= w_accept ? RSP_LIVE : IDLE;
          end else begin
            // sram_dout is only valid for one cycle, so freeze it here
            r_state <= RSP_HELD;
            r_hold  <= w_live_rdata;
          end
        end
        RSP_HELD: begin
          if (icb.i_icb_rsp_ready) r_state <= w_accept ? RSP_LIVE : IDLE;
        end
        default: r_state <= IDLE;
      endcase
      if (w_accept) begin
        r_read <= icb.i_icb_cmd_read;
        r_err  <= w_oor;
        r_usr  <= icb.i_icb_cmd_usr;
      end
    end
  end

endmodule

// File: tb/tb_icb_sram_ctrl.sv
// Self-checking bench for icb_sram_ctrl: directed scenarios plus random traffic against a transaction-level model.
module tb_icb_sram_ctrl;
  localparam int AW      = 32;
  localparam int DW      = 32;
  localparam int SRAM_AW = 10;
  localparam int USR_W   = 8;
`ifdef ICB_SRAM_RANGE_CHK_EN
  localparam bit RANGE_EN = 1'b1;
`else
  localparam bit RANGE_EN = 1'b0;
`endif

  logic clk;
  logic rst;
  logic               sram_cs;
  logic               sram_we;
  logic [DW/8-1:0]    sram_wem;
  logic [SRAM_AW-1:0] sram_addr;
  logic [DW-1:0]      sram_din;
  logic [DW-1:0]      sram_dout;
  logic               sram_ctrl_active;

  icb_sram_ctrl_if #(.AW(AW), .DW(DW), .USR_W(USR_W)) icb_bus ();

  icb_sram_ctrl #(.AW(AW), .DW(DW), .SRAM_AW(SRAM_AW), .USR_W(USR_W)) u_dut (
    .clk              (clk),
    .rst              (rst),
    .icb              (icb_bus),
    .sram_cs          (sram_cs),
    .sram_we          (sram_we),
    .sram_wem         (sram_wem),
    .sram_addr        (sram_addr),
    .sram_din         (sram_din),
    .sram_dout        (sram_dout),
    .sram_ctrl_active (sram_ctrl_active)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous SRAM: read data appears the cycle after the access.
  logic [DW-1:0] sram_mem [0:(1<<SRAM_AW)-1];
  always @(posedge clk) begin
    if (sram_cs) begin
      if (sram_we) begin
        for (int b = 0; b < DW/8; b++)
          if (sram_wem[b]) sram_mem[sram_addr][b*8 +: 8] <= sram_din[b*8 +: 8];
      end else begin
        sram_dout <= sram_mem[sram_addr];
      end
    end
  end

  // Transaction-level reference: a word array plus the single pending response.
  logic [31:0] mem_ref [0:1023];
  bit          pend;
  logic        p_err;
  logic [31:0] p_rdata;
  logic [7:0]  p_usr;

  int n_vec;
  int n_err;
  int hs_count;
  logic [31:0] hs_rdata;
  logic        hs_err;
  logic [7:0]  hs_usr_q [$];

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  // Drive one cycle of inputs, check all outputs against the model, then advance the model.
  task automatic cycle(input bit v, input bit rd, input logic [31:0] a, input logic [31:0] wd,
                       input logic [3:0] wm, input logic [7:0] u, input bit rr);
    bit acc;
    bit oor;
    bit cs_exp;
    int idx;
    icb_bus.i_icb_cmd_valid = v;
    icb_bus.i_icb_cmd_read  = rd;
    icb_bus.i_icb_cmd_addr  = a;
    icb_bus.i_icb_cmd_wdata = wd;
    icb_bus.i_icb_cmd_wmask = wm;
    icb_bus.i_icb_cmd_excl  = $urandom_range(0, 1) == 1;
    icb_bus.i_icb_cmd_usr   = u;
    icb_bus.i_icb_rsp_ready = rr;
    #3;
    acc    = v && (!pend || rr);
    oor    = RANGE_EN && (a[31:SRAM_AW+2] != 0);
    cs_exp = acc && !oor;
    chk("rsp_valid", icb_bus.i_icb_rsp_valid, pend);
    if (pend) begin
      chk("rsp_rdata", icb_bus.i_icb_rsp_rdata, p_rdata);
      chk("rsp_err", icb_bus.i_icb_rsp_err, p_err);
      chk("rsp_usr", icb_bus.i_icb_rsp_usr, p_usr);
      if (rr) begin
        hs_count++;
        hs_rdata = icb_bus.i_icb_rsp_rdata;
        hs_err   = icb_bus.i_icb_rsp_err;
        hs_usr_q.push_back(icb_bus.i_icb_rsp_usr);
      end
    end
    chk("rsp_excl_ok", icb_bus.i_icb_rsp_excl_ok, 0);
    chk("cmd_ready", icb_bus.i_icb_cmd_ready, !pend || rr);
    chk("sram_cs", sram_cs, cs_exp);
    if (cs_exp) begin
      chk("sram_addr", sram_addr, a[SRAM_AW+1:2]);
      chk("sram_we", sram_we, !rd);
      chk("sram_wem", sram_wem, rd ? 4'h0 : wm);
      if (!rd) chk("sram_din", sram_din, wd);
    end
    chk("active", sram_ctrl_active, v || pend);
    @(posedge clk);
    if (pend && rr) pend = 0;
    if (acc) begin
      idx   = int'(a[SRAM_AW+1:2]);
      pend  = 1;
      p_usr = u;
      p_err = oor;
      p_rdata = 32'h0;
      if (!oor) begin
        if (rd) p_rdata = mem_ref[idx];
        else
          for (int b = 0; b < 4; b++)
            if (wm[b]) mem_ref[idx][b*8 +: 8] = wd[b*8 +: 8];
      end
    end
    #1;
  endtask

  task automatic idle(input bit rr);
    cycle(0, 1, 32'h0, 32'h0, 4'h0, 8'h0, rr);
  endtask

  initial begin
    logic [31:0] a;
    n_vec = 0;
    n_err = 0;
    hs_count = 0;
    pend = 0;
    p_err = 0;
    p_rdata = 0;
    p_usr = 0;
    sram_dout = '0;
    for (int i = 0; i < 1024; i++) begin
      sram_mem[i] = '0;
      mem_ref[i]  = '0;
    end
    rst = 1'b1;
    icb_bus.i_icb_cmd_valid = 1'b1;
    icb_bus.i_icb_cmd_read  = 1'b1;
    icb_bus.i_icb_cmd_addr  = 32'h10;
    icb_bus.i_icb_cmd_wdata = '0;
    icb_bus.i_icb_cmd_wmask = '0;
    icb_bus.i_icb_cmd_excl  = 1'b0;
    icb_bus.i_icb_cmd_usr   = 8'h5a;
    icb_bus.i_icb_rsp_ready = 1'b0;
    #3;
    chk("rst_rsp_valid", icb_bus.i_icb_rsp_valid, 0);
    chk("rst_rsp_err", icb_bus.i_icb_rsp_err, 0);
    chk("rst_rsp_rdata", icb_bus.i_icb_rsp_rdata, 0);
    chk("rst_rsp_usr", icb_bus.i_icb_rsp_usr, 0);
    chk("rst_sram_cs", sram_cs, 0);
    chk("rst_cmd_ready", icb_bus.i_icb_cmd_ready, 1);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    // write then read back one full word
    cycle(1, 0, 32'h10, 32'hDEADBEEF, 4'hF, 8'h01, 1);
    cycle(1, 1, 32'h10, 32'h0, 4'h0, 8'h02, 1);
    idle(1);
    chk("rd_0x10", hs_rdata, 32'hDEADBEEF);
    chk("rd_0x10_err", hs_err, 0);

    // partial byte-mask write merges with the earlier word
    cycle(1, 0, 32'h20, 32'h11223344, 4'hF, 8'h03, 1);
    cycle(1, 0, 32'h20, 32'hAABBCCDD, 4'h3, 8'h04, 1);
    cycle(1, 1, 32'h20, 32'h0, 4'h0, 8'h05, 1);
    idle(1);
    chk("rd_0x20_merge", hs_rdata, 32'h1122CCDD);

    // stalled response with another command waiting
    cycle(1, 1, 32'h10, 32'h0, 4'h0, 8'h06, 1);
    repeat (5) cycle(1, 0, 32'h40, 32'h55667788, 4'hF, 8'h07, 0);
    cycle(1, 0, 32'h40, 32'h55667788, 4'hF, 8'h07, 1);
    chk("held_rdata", hs_rdata, 32'hDEADBEEF);
    idle(1);

    // 8 back-to-back reads: 8 responses within 9 cycles, usr in order
    hs_count = 0;
    hs_usr_q.delete();
    for (int i = 0; i < 8; i++) cycle(1, 1, 32'h40 + 32'(i * 4), 32'h0, 4'h0, 8'(i), 1);
    idle(1);
    chk("stream_count", hs_count, 8);
    for (int i = 0; i < 8; i++)
      if (i < hs_usr_q.size()) chk("stream_usr", hs_usr_q[i], i);

    // address above SRAM range
    cycle(1, 1, 32'h0000_1000, 32'h0, 4'h0, 8'h09, 1);
    idle(1);
    chk("range_err", hs_err, RANGE_EN);
    chk("range_rdata", hs_rdata, 0);

    // reset while a response is held
    cycle(1, 1, 32'h20, 32'h0, 4'h0, 8'h0a, 1);
    cycle(1, 1, 32'h10, 32'h0, 4'h0, 8'h0b, 0);
    chk("pre_rst_held", icb_bus.i_icb_rsp_valid, 1);
    rst = 1'b1;
    #1;
    chk("rst_mid_rsp_valid", icb_bus.i_icb_rsp_valid, 0);
    chk("rst_mid_cmd_ready", icb_bus.i_icb_cmd_ready, 1);
    chk("rst_mid_sram_cs", sram_cs, 0);
    @(posedge clk);
    #1;
    chk("rst_hold_sram_cs", sram_cs, 0);
    rst = 1'b0;
    pend = 0;
    cycle(1, 1, 32'h20, 32'h0, 4'h0, 8'h0c, 1);
    idle(1);
    chk("post_rst_read", hs_rdata, 32'h1122CCDD);

    // random traffic
    for (int i = 0; i < 400; i++) begin
      a = {($urandom_range(0, 7) == 0) ? 20'($urandom) : 20'h0,
           6'h0, 4'($urandom_range(0, 15)), 2'($urandom)};
      cycle($urandom_range(0, 9) < 7, $urandom_range(0, 1) == 1, a, $urandom,
            4'($urandom), 8'($urandom), $urandom_range(0, 9) < 7);
    end
    repeat (2) idle(1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/icb_sram_ctrl.md
ICB_SRAM_CTRL -- requirements
Module: icb_sram_ctrl

Interface
REQ-001 SHALL have parameter AW, default 32, ICB address width.
REQ-002 SHALL have parameter DW, default 32, data width (multiple of 8).
REQ-003 SHALL have parameter SRAM_AW, default 10, SRAM word-address width (depth 2^SRAM_AW).
REQ-004 SHALL have parameter USR_W, default 1, user sideband width.
REQ-005 Ports: clk  in  1  clock; one clock, all logic on rising edge.
REQ-006 Ports: rst  in  1  reset; asynchronous, active-high.
REQ-007 Ports: i_icb_cmd_valid in 1, i_icb_cmd_ready out 1  cmd handshake.
REQ-008 Ports: i_icb_cmd_read in 1, i_icb_cmd_addr in AW, i_icb_cmd_wdata in DW, i_icb_cmd_wmask in DW/8, i_icb_cmd_excl in 1, i_icb_cmd_usr in USR_W  cmd payload.
REQ-009 Ports: i_icb_rsp_valid out 1, i_icb_rsp_ready in 1  rsp handshake.
REQ-010 Ports: i_icb_rsp_err out 1, i_icb_rsp_excl_ok out 1, i_icb_rsp_rdata out DW, i_icb_rsp_usr out USR_W  rsp payload.
REQ-011 Ports: sram_cs out 1, sram_we out 1, sram_wem out DW/8, sram_addr out SRAM_AW, sram_din out DW  SRAM request.
REQ-012 Ports: sram_dout in DW  SRAM read data, valid only the cycle after a read access.
REQ-013 Ports: sram_ctrl_active out 1  high when cmd_valid or any response pending.

Function
REQ-014 Sits directly downstream of the ICB command/response buffer; one transaction in flight max.
REQ-015 Cmd accept = cmd_valid & cmd_ready; cmd_ready = (state==IDLE) | (i_icb_rsp_valid & i_icb_rsp_ready).
REQ-016 On accept: sram_cs=1 same cycle (combinational), sram_we=~read, sram_wem=read?0:wmask, sram_addr=addr[SRAM_AW+1:2], sram_din=wdata.
REQ-017 FSM states IDLE, RSP_LIVE, RSP_HELD; reset to IDLE.
REQ-018 IDLE: accept -> RSP_LIVE; else stay.
REQ-019 RSP_LIVE: rsp_valid=1, rdata=sram_dout (read) or 0 (write); rsp_ready & new accept -> RSP_LIVE; rsp_ready only -> IDLE; no rsp_ready -> RSP_HELD capturing sram_dout into hold register.
REQ-020 RSP_HELD: rsp_valid=1, rdata=hold register; rsp_ready & accept -> RSP_LIVE; rsp_ready only -> IDLE; else stay, payload stable.
REQ-021 Latency: rsp_valid asserts exactly 1 cycle after cmd accept; back-to-back throughput 1 transaction/cycle when rsp_ready held high.
REQ-022 Registered per transaction at accept: read flag, usr, err flag; rsp_usr returns the accepted cmd_usr.
REQ-023 rsp_excl_ok SHALL be 0 always; excl commands are executed as normal accesses.
REQ-024 rsp_err=0 except per REQ-031.
REQ-025 sram_ctrl_active = i_icb_cmd_valid | (state!=IDLE).

Reset
REQ-026 rst asserted (any time, including mid-transaction) SHALL force state IDLE immediately; pending response discarded.
REQ-027 Reset values: i_icb_rsp_valid=0, rsp_err=0, rsp_rdata=0, rsp_usr=0, sram_cs=0, hold register=0, cmd_ready=1.
REQ-028 sram_cs SHALL be 0 while rst asserted regardless of cmd_valid.

Configuration
REQ-029 Macro ICB_SRAM_RANGE_CHK_EN selects address range checking.
REQ-030 Without macro: addr bits above SRAM_AW+1 ignored; all addresses alias into SRAM.
REQ-031 With macro: if any of addr[AW-1:SRAM_AW+2] is 1, cmd accepted normally, sram_cs=0, response follows REQ-019/020 with rsp_err=1, rdata=0.

Verification
REQ-032 Write addr 0x10 wdata 0xDEADBEEF wmask 0xF, then read 0x10 -> rsp rdata 0xDEADBEEF, err 0, one cycle after each accept.
REQ-033 Write 0x11223344 mask 0xF then 0xAABBCCDD mask 0x3 to 0x20, read 0x20 -> 0x1122CCDD.
REQ-034 Read 0x10 with rsp_ready low 5 cycles -> state RSP_HELD, rdata stable 0xDEADBEEF, cmd_ready 0, sram_cs 0 throughout.
REQ-035 Stream 8 reads with rsp_ready=1 -> 8 responses in 9 consecutive cycles, usr 0..7 in order.
REQ-036 With ICB_SRAM_RANGE_CHK_EN, read 0x0000_1000 (SRAM_AW=10) -> sram_cs 0, rsp err 1, rdata 0; without it -> sram_addr 0, err 0.
REQ-037 Assert rst while in RSP_HELD -> rsp_valid 0 same cycle, IDLE after release, next read completes normally.
